// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand-entry path: FSM state codes
// and the default operand width.
package calc_pkg;

    localparam int DEFAULT_WIDTH = 5;

    typedef logic [1:0] estado_t;

    localparam estado_t ST_IDLE   = 2'b00;
    localparam estado_t ST_WAIT_B = 2'b01;
    localparam estado_t ST_DONE   = 2'b10;

endpackage

// File: rtl/control_operandos_antirrebote.sv
// Pushbutton front-end: multi-stage synchroniser, counter-based debounce and a
// one-cycle pulse on each accepted press (release edges are silent).
module antirrebote #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic pulse
);

    localparam int             CW       = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   stable_q, stable_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   pulse_q, pulse_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        sync_d   = {sync_q[SYNC_STAGES-2:0], btn_in};
        stable_d = stable_q;
        cnt_d    = '0;
        pulse_d  = 1'b0;
        // Any cycle where the synced input agrees with the accepted level restarts the count.
        if (synced != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = synced;
                pulse_d  = synced;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values, matching real hardware.
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/control_operandos.sv
// Operand-entry sequencer: captures operand A then B from the switches on
// successive LOAD presses and offers {op_a, op_b} over a valid/ready handshake.
module control_operandos
    import calc_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   sw,
    input  logic               btn_load,
    input  logic               btn_clear,
    input  logic               word_ready,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    output logic [2*WIDTH-1:0] word,
    output logic               word_valid,
    output logic [1:0]         estado
);

    logic load_pulse, clear_pulse;

    antirrebote #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_ar_load (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_in(btn_load),
        .pulse (load_pulse)
    );

    antirrebote #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_ar_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_in(btn_clear),
        .pulse (clear_pulse)
    );

    estado_t          state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        case (state_q)
            ST_IDLE: begin
                if (load_pulse) begin
                    op_a_d  = sw;
                    op_b_d  = '0;
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (load_pulse) begin
                    op_b_d  = sw;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Operands are held after acceptance so the display keeps the last word.
                if (word_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Clear overrides a same-cycle load or handshake.
        if (clear_pulse) begin
            op_a_d  = '0;
            op_b_d  = '0;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
        end
    end

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign word       = {op_a_q, op_b_q};
    assign word_valid = (state_q == ST_DONE);
    assign estado     = state_q;

endmodule

// File: tb/tb_control_operandos.sv
// Self-checking bench for control_operandos: directed scenarios plus random
// load/clear/handshake sequences checked against a transaction-level model.
module tb_control_operandos;

    localparam int W  = 5;
    localparam int SS = 2;
    localparam int DC = 4;
    localparam int VW = 2 + 1 + W + W + 2 * W;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   sw = '0;
    logic           btn_load = 1'b0;
    logic           btn_clear = 1'b0;
    logic           word_ready = 1'b0;
    logic [W-1:0]   op_a, op_b;
    logic [2*W-1:0] word;
    logic           word_valid;
    logic [1:0]     estado;

    control_operandos #(
        .WIDTH       (W),
        .SYNC_STAGES (SS),
        .DEBOUNCE_CYC(DC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .btn_load  (btn_load),
        .btn_clear (btn_clear),
        .word_ready(word_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .word      (word),
        .word_valid(word_valid),
        .estado    (estado)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: phase 0 = nothing entered, 1 = A entered, 2 = pair complete.
    int         m_phase = 0;
    logic [W-1:0] m_a = '0, m_b = '0;

    int valid_cycles = 0;
    always @(negedge clk) if (word_valid === 1'b1) valid_cycles = valid_cycles + 1;

    function automatic logic [VW-1:0] obs_vec();
        return {estado, word_valid, op_a, op_b, word};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [1:0] ph;
        ph = 2'(m_phase);
        return {ph, (m_phase == 2), m_a, m_b, m_a, m_b};
    endfunction

    task automatic m_load(input logic [W-1:0] v);
        if (m_phase == 0) begin
            m_a = v; m_b = '0; m_phase = 1;
        end else if (m_phase == 1) begin
            m_b = v; m_phase = 2;
            if (word_ready) m_phase = 0;
        end
    endtask

    task automatic m_clear();
        m_a = '0; m_b = '0; m_phase = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_load(input logic [W-1:0] v);
        @(negedge clk);
        sw = v;
        btn_load = 1'b1;
        cycles(12);
        btn_load = 1'b0;
        cycles(10);
        sw = W'($urandom);
        cycles(2);
        m_load(v);
    endtask

    task automatic press_clear();
        @(negedge clk);
        btn_clear = 1'b1;
        cycles(12);
        btn_clear = 1'b0;
        cycles(12);
        m_clear();
    endtask

    task automatic handshake();
        @(negedge clk);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        if (m_phase == 2) m_phase = 0;
        cycles(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycles(3);
        checks++;
        if (obs_vec() !== '0) begin
            failures++;
            $display("FAIL reset_state: got %h want %h", obs_vec(), {VW{1'b0}});
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycles(3);
    endtask

    task automatic test_basic_pair();
        logic [2*W-1:0] held;
        press_load(5'h13);
        press_load(5'h0A);
        checks++;
        if (obs_vec() !== exp_vec() || word !== 10'h26A) begin
            failures++;
            $display("FAIL basic_pair: got %h want %h (word %h want 26a)", obs_vec(), exp_vec(), word);
        end
        held = word;
        for (int i = 0; i < 20; i++) begin
            sw = W'($urandom);
            @(negedge clk);
            checks++;
            if (word_valid !== 1'b1 || word !== held) begin
                failures++;
                $display("FAIL valid_hold[%0d]: valid=%b word=%h want valid=1 word=%h", i, word_valid, word, held);
            end
        end
        handshake();
        checks++;
        if (obs_vec() !== exp_vec() || estado !== 2'b00) begin
            failures++;
            $display("FAIL accept: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_latency();
        int n;
        logic [W-1:0] v;
        v = W'($urandom_range(1, 31));
        n = 0;
        @(negedge clk);
        sw = v;
        btn_load = 1'b1;
        while (estado === 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < SS + DC || n > SS + DC + 4) begin
            failures++;
            $display("FAIL press_latency: got %0d cycles want %0d..%0d", n, SS + DC, SS + DC + 4);
        end
        btn_load = 1'b0;
        cycles(12);
        m_load(v);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL latency_capture: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic glitches(input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            btn_load = 1'b1;
            cycles(DC - 1);
            btn_load = 1'b0;
            cycles(3);
        end
    endtask

    task automatic test_bounce();
        logic [W-1:0] v;
        v = W'($urandom);
        sw = v;
        glitches(5);
        cycles(10);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL glitch_only: got %h want %h", obs_vec(), exp_vec());
        end
        glitches(5);
        @(negedge clk);
        btn_load = 1'b1;
        cycles(10);
        btn_load = 1'b0;
        cycles(12);
        m_load(v);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL bounce_one_capture: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_clear_wins();
        if (m_phase != 1) begin
            press_clear();
            press_load(W'($urandom_range(1, 31)));
        end
        @(negedge clk);
        sw = W'($urandom);
        btn_load = 1'b1;
        btn_clear = 1'b1;
        cycles(12);
        btn_load = 1'b0;
        btn_clear = 1'b0;
        cycles(12);
        m_clear();
        checks++;
        if (obs_vec() !== exp_vec() || estado !== 2'b00) begin
            failures++;
            $display("FAIL clear_over_load: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_load_in_done();
        press_load(W'($urandom));
        press_load(W'($urandom));
        press_load(~m_b);
        checks++;
        if (obs_vec() !== exp_vec() || word_valid !== 1'b1) begin
            failures++;
            $display("FAIL load_ignored_in_done: got %h want %h", obs_vec(), exp_vec());
        end
        handshake();
    endtask

    task automatic test_async_reset();
        logic [W-1:0] v;
        press_load(W'($urandom_range(1, 31)));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        m_clear();
        #1;
        checks++;
        if (obs_vec() !== '0) begin
            failures++;
            $display("FAIL async_reset: got %h want %h", obs_vec(), {VW{1'b0}});
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);
        v = W'($urandom_range(1, 31));
        press_load(v);
        checks++;
        if (op_a !== v || estado !== 2'b01 || obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL first_after_reset: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_ready_always();
        int v0;
        if (m_phase != 0) press_clear();
        word_ready = 1'b1;
        v0 = valid_cycles;
        for (int i = 0; i < 3; i++) begin
            press_load(W'($urandom));
            press_load(W'($urandom));
        end
        cycles(4);
        checks++;
        if (valid_cycles - v0 !== 3) begin
            failures++;
            $display("FAIL valid_pulses: got %0d want 3", valid_cycles - v0);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL ready_always_state: got %h want %h", obs_vec(), exp_vec());
        end
        word_ready = 1'b0;
    endtask

    task automatic test_random();
        int op;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            if (op < 6)      press_load(W'($urandom));
            else if (op < 8) handshake();
            else             press_clear();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random[%0d] op=%0d: got %h want %h", i, op, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_pair();
        test_latency();
        test_bounce();
        test_clear_wins();
        test_load_in_done();
        test_async_reset();
        test_ready_always();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
